debug_master_mc: RTL and testbench

DEBUG_MASTER_MC -- requirements
Module: debug_master_mc

---
 rtl/debug_master_pkg.sv | 36 +++
 rtl/debug_word_fifo.sv | 81 ++++++++
 rtl/debug_master_mc.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_debug_master_mc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_master_pkg.sv
// debug_master_pkg
// Shared definitions for the debug ring master: command codes, FSM state
// encoding, err_flags bit positions and a command length check.
package debug_master_pkg;

  // Command codes carried on cmd_a.
  typedef enum logic [1:0] {
    CMD_WDATA = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_SHIFT = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  // Transaction state machine encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Bit positions inside err_flags = {cmd_err, tx_underflow, rx_overflow}.
  localparam int ERR_RX_OVERFLOW  = 0;
  localparam int ERR_TX_UNDERFLOW = 1;
  localparam int ERR_CMD          = 2;

  localparam int WORD_BITS = 32;

  // A SHIFT word count is usable when it is non-zero and within the limit.
  function automatic logic shift_len_ok(input logic [7:0] n,
                                        input int unsigned max_words);
    return (n != 8'd0) && ({24'd0, n} <= max_words);
  endfunction

endpackage

// File: rtl/debug_word_fifo.sv
// debug_word_fifo
// 32-bit synchronous first-word-fall-through FIFO with an occupancy output.
// The head word is visible on rdata_o whenever empty_o is low.
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   flush_i        empties the FIFO (wins over push/pop in the same cycle)
//   push_i/wdata_i write request and data (dropped when full, unless a pop
//                  frees the slot in the same cycle)
//   pop_i          advance the head (ignored when empty)
//   rdata_o        head word
//   empty_o        no words stored
//   level_o        number of stored words, 0..DEPTH
module debug_word_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [31:0]              wdata_i,
  input  logic                     pop_i,
  output logic [31:0]              rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;

  logic full;
  logic do_push;
  logic do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full || do_pop);

  // Storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are AW bits wide with DEPTH a power of two, so they wrap
  // modulo DEPTH on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LW'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/debug_master_mc.sv
// debug_master_mc
// Master for up to eight serial debug rings. Words queued in a TX FIFO are
// shifted LSB first into the selected ring; the bits returning from the ring
// are reassembled into 32-bit words and queued in an FWFT RX FIFO.
// Ports:
//   mclk, mrst           clock, asynchronous active-high reset
//   cmd_a/cmd_data/cmd_we command interface (WDATA, LOAD, SHIFT, CLEAR)
//   debug_do/debug_sl    per-ring serial data and strobe
//   debug_di             per-ring returned serial data
//   rd_data/rd_valid/rd_ready  RX FIFO read port (FWFT)
//   busy                 transaction in progress
//   tx_level/rx_level    FIFO occupancies
//   err_flags            sticky {cmd_err, tx_underflow, rx_overflow}
//   done_tgl             toggles once per completed transaction
module debug_master_mc
  import debug_master_pkg::*;
#(
  parameter int NUM_RINGS   = 2,
  parameter int CMD_LATENCY = 2,
  parameter int MAX_WORDS   = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          mclk,
  input  logic                          mrst,
  input  logic [1:0]                    cmd_a,
  input  logic [31:0]                   cmd_data,
  input  logic                          cmd_we,
  output logic [NUM_RINGS-1:0]          debug_do,
  output logic [NUM_RINGS-1:0]          debug_sl,
  input  logic [NUM_RINGS-1:0]          debug_di,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [2:0]                    err_flags,
  output logic                          done_tgl
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Registered state.
  state_e                 state_q;
  logic [NUM_RINGS-1:0]   ring_mask_q;
  logic                   phase_q;      // 0: strobe cycle, 1: hold cycle
  logic [4:0]             bit_cnt_q;    // bit index inside current TX word
  logic [7:0]             words_left_q; // TX words left including current
  logic [31:0]            tx_sr_q;      // current bit always at [0]
  logic [3:0]             cnt_q;        // LOAD / DRAIN cycle counter
  logic [NUM_RINGS-1:0]   sl_q;
  logic [NUM_RINGS-1:0]   do_q;
  logic                   done_tgl_q;
  logic [2:0]             err_q;
  logic [CMD_LATENCY-1:0] smp_pipe_q;   // delayed copies of the hold-cycle marker
  logic [CMD_LATENCY-1:0] smp_pipe_d;
  logic [31:0]            rx_sr_q;
  logic [4:0]             rx_cnt_q;

  // Command decode.
  logic [2:0]           cmd_ring;
  logic [7:0]           cmd_n;
  logic [NUM_RINGS-1:0] cmd_mask;
  logic                 is_wdata, is_load, is_shift, is_clear;
  logic                 idle, ring_ok, start_load, start_shift, cmd_bad;

  assign cmd_ring = cmd_data[10:8];
  assign cmd_n    = cmd_data[7:0];
  assign is_wdata = cmd_we && (cmd_a == CMD_WDATA);
  assign is_load  = cmd_we && (cmd_a == CMD_LOAD);
  assign is_shift = cmd_we && (cmd_a == CMD_SHIFT);
  assign is_clear = cmd_we && (cmd_a == CMD_CLEAR);

  // One-hot ring select; a ring number beyond NUM_RINGS yields all zeros.
  for (genvar gi = 0; gi < NUM_RINGS; gi++) begin : g_ring_mask
    assign cmd_mask[gi] = (cmd_ring == 3'(gi));
  end

  assign idle        = (state_q == S_IDLE);
  assign ring_ok     = ({29'd0, cmd_ring} < 32'(NUM_RINGS));
  assign start_load  = is_load && idle && ring_ok;
  assign start_shift = is_shift && idle && ring_ok &&
                       shift_len_ok(cmd_n, 32'(MAX_WORDS));
  assign cmd_bad     = (is_load && !start_load) || (is_shift && !start_shift);

  // TX FIFO interface: a word is fetched at every word boundary, including
  // the edge that accepts the SHIFT command.
  logic [31:0]   tx_rdata;
  logic          tx_empty;
  logic [LW-1:0] tx_level_w;
  logic          word_start;
  logic          tx_pop;
  logic [31:0]   tx_word;

  assign word_start = start_shift ||
                      ((state_q == S_SHIFT) && phase_q && (bit_cnt_q == 5'd31) &&
                       (words_left_q != 8'd1) && !is_clear);
  assign tx_pop     = word_start && !tx_empty;
  assign tx_word    = tx_empty ? 32'd0 : tx_rdata;

  debug_word_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (mclk),
    .rst_i   (mrst),
    .flush_i (is_clear),
    .push_i  (is_wdata),
    .wdata_i (cmd_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .empty_o (tx_empty),
    .level_o (tx_level_w)
  );

  // Receive path. The hold cycle of bit k is cycle 2k+1; delaying that marker
  // by CMD_LATENCY cycles lands the sample in cycle 2k+1+CMD_LATENCY.
  logic        smp_tap;
  logic        smp;
  logic        di_bit;
  logic [31:0] rx_word;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_empty;
  logic        rx_full;
  logic [LW-1:0] rx_level_w;
  logic [31:0] rx_rdata;

  assign smp_tap = (state_q == S_SHIFT) && phase_q;

  if (CMD_LATENCY == 1) begin : g_pipe1
    assign smp_pipe_d = smp_tap;
  end else begin : g_pipen
    assign smp_pipe_d = {smp_pipe_q[CMD_LATENCY-2:0], smp_tap};
  end

  assign smp     = smp_pipe_q[CMD_LATENCY-1];
  assign di_bit  = |(debug_di & ring_mask_q);
  assign rx_word = {di_bit, rx_sr_q[31:1]};
  assign rx_push = smp && (rx_cnt_q == 5'd31) && !is_clear;
  assign rx_pop  = rd_valid && rd_ready;
  assign rx_full = (rx_level_w == LW'(FIFO_DEPTH));

  debug_word_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (mclk),
    .rst_i   (mrst),
    .flush_i (is_clear),
    .push_i  (rx_push),
    .wdata_i (rx_word),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .empty_o (rx_empty),
    .level_o (rx_level_w)
  );

  // Error flags and receive shift register.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      err_q      <= '0;
      smp_pipe_q <= '0;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      if (is_clear) begin
        err_q <= '0;
      end else begin
        if (cmd_bad) err_q[ERR_CMD] <= 1'b1;
        if (word_start && tx_empty) err_q[ERR_TX_UNDERFLOW] <= 1'b1;
        if (rx_push && rx_full && !rx_pop) err_q[ERR_RX_OVERFLOW] <= 1'b1;
      end
      // CLEAR discards any partially assembled word along with in-flight samples.
      if (is_clear) begin
        smp_pipe_q <= '0;
        rx_sr_q    <= '0;
        rx_cnt_q   <= '0;
      end else begin
        smp_pipe_q <= smp_pipe_d;
        if (smp) begin
          rx_sr_q  <= rx_word;
          rx_cnt_q <= rx_cnt_q + 5'd1;
        end
      end
    end
  end

  // Transaction state machine with registered ring outputs.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q      <= S_IDLE;
      ring_mask_q  <= '0;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      words_left_q <= '0;
      tx_sr_q      <= '0;
      cnt_q        <= '0;
      sl_q         <= '0;
      do_q         <= '0;
      done_tgl_q   <= 1'b0;
    end else if (is_clear && !idle) begin
      // Abort: back to IDLE with all ring outputs quiet, no completion toggle.
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      words_left_q <= '0;
      tx_sr_q      <= '0;
      cnt_q        <= '0;
      sl_q         <= '0;
      do_q         <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_load) begin
            state_q     <= S_LOAD;
            ring_mask_q <= cmd_mask;
            sl_q        <= cmd_mask;
            do_q        <= '0;
            cnt_q       <= '0;
          end else if (start_shift) begin
            state_q      <= S_SHIFT;
            ring_mask_q  <= cmd_mask;
            words_left_q <= cmd_n;
            tx_sr_q      <= tx_word;
            bit_cnt_q    <= '0;
            phase_q      <= 1'b0;
            sl_q         <= cmd_mask;
            do_q         <= cmd_mask & {NUM_RINGS{tx_word[0]}};
          end
        end
        S_LOAD: begin
          // Strobe held for two cycles: cnt_q = 0, 1.
          if (cnt_q == 4'd1) begin
            state_q    <= S_DONE;
            sl_q       <= '0;
            done_tgl_q <= ~done_tgl_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_SHIFT: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            sl_q    <= '0;
          end else begin
            phase_q <= 1'b0;
            if (bit_cnt_q == 5'd31) begin
              if (words_left_q == 8'd1) begin
                state_q      <= S_DRAIN;
                words_left_q <= '0;
                bit_cnt_q    <= '0;
                tx_sr_q      <= '0;
                cnt_q        <= '0;
                do_q         <= '0;
              end else begin
                words_left_q <= words_left_q - 8'd1;
                bit_cnt_q    <= '0;
                tx_sr_q      <= tx_word;
                sl_q         <= ring_mask_q;
                do_q         <= ring_mask_q & {NUM_RINGS{tx_word[0]}};
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              tx_sr_q   <= tx_sr_q >> 1;
              sl_q      <= ring_mask_q;
              do_q      <= ring_mask_q & {NUM_RINGS{tx_sr_q[1]}};
            end
          end
        end
        S_DRAIN: begin
          // CMD_LATENCY+1 cycles so the last returned bit is captured.
          if (cnt_q == 4'(CMD_LATENCY)) begin
            state_q    <= S_DONE;
            done_tgl_q <= ~done_tgl_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign debug_sl  = sl_q;
  assign debug_do  = do_q;
  assign busy      = (state_q != S_IDLE);
  assign done_tgl  = done_tgl_q;
  assign err_flags = err_q;
  assign rd_data   = rx_rdata;
  assign rd_valid  = !rx_empty;
  assign tx_level  = tx_level_w;
  assign rx_level  = rx_level_w;

endmodule

// File: tb/tb_debug_master_mc.sv
module tb_debug_master_mc;

  logic        mclk;
  logic        mrst;
  logic [1:0]  cmd_a;
  logic [31:0] cmd_data;
  logic        cmd_we;
  logic [1:0]  debug_do;
  logic [1:0]  debug_sl;
  logic [1:0]  debug_di;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic [3:0]  tx_level;
  logic [3:0]  rx_level;
  logic [2:0]  err_flags;
  logic        done_tgl;

  int n_tests;
  int n_fail;
  logic exp_tgl;

  debug_master_mc #(
    .NUM_RINGS(2), .CMD_LATENCY(2), .MAX_WORDS(4), .FIFO_DEPTH(8)
  ) dut (
    .mclk(mclk), .mrst(mrst), .cmd_a(cmd_a), .cmd_data(cmd_data), .cmd_we(cmd_we),
    .debug_do(debug_do), .debug_sl(debug_sl), .debug_di(debug_di),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
    .tx_level(tx_level), .rx_level(rx_level), .err_flags(err_flags), .done_tgl(done_tgl)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Ring loopback: debug_di is debug_do delayed by CMD_LATENCY+1 = 3 cycles.
  logic [1:0] dly0, dly1, dly2;
  always @(posedge mclk) begin
    dly0 <= debug_do;
    dly1 <= dly0;
    dly2 <= dly1;
  end
  assign debug_di = dly2;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic send(input logic [1:0] a, input logic [31:0] d);
    cmd_a    = a;
    cmd_data = d;
    cmd_we   = 1'b1;
    step();
    cmd_we   = 1'b0;
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      step();
      cyc++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cycles;
    int nsel_bad;
    n_tests  = 0;
    n_fail   = 0;
    exp_tgl  = 1'b0;
    mrst     = 1'b1;
    cmd_a    = 2'd0;
    cmd_data = 32'd0;
    cmd_we   = 1'b0;
    rd_ready = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_sl",    {30'd0, debug_sl}, 32'd0);
    check("rst_do",    {30'd0, debug_do}, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_err",   {29'd0, err_flags}, 32'd0);
    check("rst_tgl",   {31'd0, done_tgl}, 32'd0);
    check("rst_txlvl", {28'd0, tx_level}, 32'd0);
    check("rst_rxlvl", {28'd0, rx_level}, 32'd0);
    mrst = 1'b0;
    step();

    // Loopback ring 1, two words.
    send(2'd0, 32'hA5A5_0F0F);
    send(2'd0, 32'h1234_5678);
    check("lb_txlvl", {28'd0, tx_level}, 32'd2);
    send(2'd2, 32'h0000_0102);
    check("lb_busy0", {31'd0, busy}, 32'd1);
    check("lb_txpop", {28'd0, tx_level}, 32'd1);
    check("lb_sl_c0", {30'd0, debug_sl}, 32'd2);
    check("lb_do_c0", {30'd0, debug_do}, 32'd2);
    step();
    check("lb_sl_c1", {30'd0, debug_sl}, 32'd0);
    check("lb_do_c1", {30'd0, debug_do}, 32'd2);
    cycles = 1;
    nsel_bad = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      if (debug_sl[0] | debug_do[0]) nsel_bad++;
      step();
      cycles++;
    end
    exp_tgl = ~exp_tgl;
    check("lb_busy_cycles", cycles, 32'd132);
    check("lb_ring0_quiet", nsel_bad, 32'd0);
    check("lb_rxlvl", {28'd0, rx_level}, 32'd2);
    check("lb_word0", rd_data, 32'hA5A5_0F0F);
    pop();
    check("lb_word1", rd_data, 32'h1234_5678);
    pop();
    check("lb_valid", {31'd0, rd_valid}, 32'd0);
    check("lb_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});
    check("lb_err", {29'd0, err_flags}, 32'd0);

    // LOAD ring 0.
    send(2'd1, 32'h0000_0000);
    check("ld_sl_c0", {30'd0, debug_sl}, 32'd1);
    step();
    check("ld_sl_c1", {30'd0, debug_sl}, 32'd1);
    step();
    check("ld_sl_c2", {30'd0, debug_sl}, 32'd0);
    run_to_idle("ld_idle");
    exp_tgl = ~exp_tgl;
    check("ld_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});

    // SHIFT n=3 with one TX word.
    send(2'd0, 32'hDEAD_BEEF);
    send(2'd2, 32'h0000_0103);
    run_to_idle("uf_idle");
    exp_tgl = ~exp_tgl;
    check("uf_rxlvl", {28'd0, rx_level}, 32'd3);
    check("uf_w0", rd_data, 32'hDEAD_BEEF);
    pop();
    check("uf_w1", rd_data, 32'd0);
    pop();
    check("uf_w2", rd_data, 32'd0);
    pop();
    check("uf_err", {29'd0, err_flags}, 32'd2);
    check("uf_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});
    send(2'd3, 32'd0);
    check("uf_clr", {29'd0, err_flags}, 32'd0);

    // RX overflow: nine one-word shifts with no reads.
    for (int i = 0; i < 9; i++) begin
      send(2'd0, 32'h1000_0000 + i);
      send(2'd2, 32'h0000_0101);
      run_to_idle("ov_idle");
      exp_tgl = ~exp_tgl;
    end
    check("ov_rxlvl", {28'd0, rx_level}, 32'd8);
    check("ov_err", {29'd0, err_flags}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("ov_word", rd_data, 32'h1000_0000 + i);
      pop();
    end
    check("ov_empty", {28'd0, rx_level}, 32'd0);
    check("ov_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});
    send(2'd3, 32'd0);

    // Illegal commands.
    send(2'd0, 32'h0000_0055);
    send(2'd2, 32'h0000_0101);
    send(2'd2, 32'h0000_0101);
    check("bad_busy_err", {29'd0, err_flags}, 32'd4);
    run_to_idle("bad_idle");
    exp_tgl = ~exp_tgl;
    check("bad_rxlvl", {28'd0, rx_level}, 32'd1);
    check("bad_word", rd_data, 32'h0000_0055);
    pop();
    send(2'd3, 32'd0);
    check("bad_clr0", {29'd0, err_flags}, 32'd0);
    send(2'd2, 32'h0000_0701);
    check("bad_ring_busy", {31'd0, busy}, 32'd0);
    check("bad_ring_err", {29'd0, err_flags}, 32'd4);
    send(2'd3, 32'd0);
    send(2'd2, 32'h0000_0000);
    check("bad_n0_busy", {31'd0, busy}, 32'd0);
    check("bad_n0_err", {29'd0, err_flags}, 32'd4);
    send(2'd3, 32'd0);
    send(2'd2, 32'h0000_0005);
    check("bad_n5_busy", {31'd0, busy}, 32'd0);
    check("bad_n5_err", {29'd0, err_flags}, 32'd4);
    send(2'd3, 32'd0);
    check("bad_clr", {29'd0, err_flags}, 32'd0);
    check("bad_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});

    // TX full: drop on full, simultaneous push and pop keeps level.
    for (int i = 0; i < 8; i++) send(2'd0, 32'h2000_0000 + i);
    check("tf_full", {28'd0, tx_level}, 32'd8);
    send(2'd0, 32'h0000_FFFF);
    check("tf_drop", {28'd0, tx_level}, 32'd8);
    send(2'd2, 32'h0000_0102);
    check("tf_pop", {28'd0, tx_level}, 32'd7);
    repeat (5) step();
    send(2'd0, 32'h3000_0000);
    check("tf_refill", {28'd0, tx_level}, 32'd8);
    repeat (57) step();
    send(2'd0, 32'h3000_0001);
    check("tf_pushpop", {28'd0, tx_level}, 32'd8);
    run_to_idle("tf_idle");
    exp_tgl = ~exp_tgl;
    check("tf_w0", rd_data, 32'h2000_0000);
    pop();
    check("tf_w1", rd_data, 32'h2000_0001);
    pop();
    send(2'd3, 32'd0);
    check("tf_flush", {28'd0, tx_level}, 32'd0);

    // CLEAR at bit 40 of a two-word shift.
    send(2'd0, 32'hCAFE_F00D);
    send(2'd0, 32'h0BAD_CAFE);
    send(2'd2, 32'h0000_0102);
    repeat (80) step();
    check("ca_rx_before", {28'd0, rx_level}, 32'd1);
    send(2'd3, 32'd0);
    check("ca_busy", {31'd0, busy}, 32'd0);
    check("ca_sl", {30'd0, debug_sl}, 32'd0);
    check("ca_rxlvl", {28'd0, rx_level}, 32'd0);
    repeat (10) step();
    check("ca_rx_after", {28'd0, rx_level}, 32'd0);
    check("ca_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});

    // mrst at bit 40 of a two-word shift.
    send(2'd0, 32'hCAFE_F00D);
    send(2'd0, 32'h0BAD_CAFE);
    send(2'd2, 32'h0000_0102);
    repeat (80) step();
    check("ra_rx_before", {28'd0, rx_level}, 32'd1);
    mrst = 1'b1;
    #1;
    check("ra_busy", {31'd0, busy}, 32'd0);
    check("ra_rxlvl", {28'd0, rx_level}, 32'd0);
    step();
    mrst = 1'b0;
    exp_tgl = 1'b0;
    repeat (10) step();
    check("ra_rx_after", {28'd0, rx_level}, 32'd0);
    check("ra_busy_after", {31'd0, busy}, 32'd0);
    check("ra_tgl", {31'd0, done_tgl}, {31'd0, exp_tgl});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
